// File: rtl/regfile_wb_arbiter.sv
// Arbitrates three writeback requesters onto the single register-file write port.
// Round-robin or fixed priority, registered write port, saturating contention counter.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADR_W  = 5,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req0Valid,
    input  logic [ADR_W-1:0]  Req0Adr,
    input  logic [DATA_W-1:0] Req0Data,
    output logic              Req0Ready,
    input  logic              Req1Valid,
    input  logic [ADR_W-1:0]  Req1Adr,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              Req1Ready,
    input  logic              Req2Valid,
    input  logic [ADR_W-1:0]  Req2Adr,
    input  logic [DATA_W-1:0] Req2Data,
    output logic              Req2Ready,
    output logic              WE,
    output logic [ADR_W-1:0]  WAdr,
    output logic [DATA_W-1:0] Din,
    output logic [2:0]        GntOH,
    output logic [15:0]       ConflictCnt
);

    localparam int unsigned N_REQ = 3;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 16;

    // Index of the requester that follows a in the wrapping 0,1,2 order, b steps on.
    function automatic logic [PTR_W-1:0] wrap3(input logic [PTR_W-1:0] a,
                                               input logic [PTR_W-1:0] b);
        logic [PTR_W:0] sum;
        sum = (PTR_W+1)'(a) + (PTR_W+1)'(b);
        if (sum >= (PTR_W+1)'(N_REQ)) begin
            sum = sum - (PTR_W+1)'(N_REQ);
        end
        return PTR_W'(sum);
    endfunction

    logic [N_REQ-1:0]  valid_c;
    logic [N_REQ-1:0]  gnt_c;
    logic [PTR_W-1:0]  start_c;
    logic [PTR_W-1:0]  idx_c;
    logic [PTR_W-1:0]  cand_c;
    logic              any_c;
    logic              multi_c;
    logic [ADR_W-1:0]  sel_adr_c;
    logic [DATA_W-1:0] sel_data_c;

    logic              we_q, we_d;
    logic [ADR_W-1:0]  wadr_q, wadr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [N_REQ-1:0]  gnt_oh_q, gnt_oh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  last_q, last_d;

    assign valid_c = {Req2Valid, Req1Valid, Req0Valid};
    assign multi_c = (Req0Valid & Req1Valid) | (Req0Valid & Req2Valid) | (Req1Valid & Req2Valid);

    // Winner selection; nothing is granted while reset is held.
    always_comb begin
        any_c   = 1'b0;
        idx_c   = '0;
        cand_c  = '0;
        start_c = wrap3(last_q, PTR_W'(1));
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (RR_EN) begin
                cand_c = wrap3(start_c, PTR_W'(i));
            end else begin
                cand_c = PTR_W'(i);
            end
            if (!any_c && valid_c[cand_c]) begin
                any_c = 1'b1;
                idx_c = cand_c;
            end
        end
        if (Rst) begin
            any_c = 1'b0;
        end
        gnt_c = any_c ? (N_REQ'(1) << idx_c) : '0;
    end

    assign Req0Ready = gnt_c[0];
    assign Req1Ready = gnt_c[1];
    assign Req2Ready = gnt_c[2];

    always_comb begin
        case (idx_c)
            2'd0:    begin sel_adr_c = Req0Adr; sel_data_c = Req0Data; end
            2'd1:    begin sel_adr_c = Req1Adr; sel_data_c = Req1Data; end
            default: begin sel_adr_c = Req2Adr; sel_data_c = Req2Data; end
        endcase
    end

    // Next-state for the write port, grant pointer and contention counter.
    always_comb begin
        we_d     = 1'b0;
        gnt_oh_d = '0;
        wadr_d   = wadr_q;
        din_d    = din_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        if (any_c) begin
            we_d     = |sel_adr_c;
            gnt_oh_d = gnt_c;
            wadr_d   = sel_adr_c;
            din_d    = sel_data_c;
            last_d   = idx_c;
        end
        if (multi_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            we_q     <= 1'b0;
            wadr_q   <= '0;
            din_q    <= '0;
            gnt_oh_q <= '0;
            cnt_q    <= '0;
            last_q   <= PTR_W'(2);
        end else begin
            we_q     <= we_d;
            wadr_q   <= wadr_d;
            din_q    <= din_d;
            gnt_oh_q <= gnt_oh_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign WE          = we_q;
    assign WAdr        = wadr_q;
    assign Din         = din_q;
    assign GntOH       = gnt_oh_q;
    assign ConflictCnt = cnt_q;

endmodule
